// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types for the memory stage: opcode constants,
// load/store funct3 encodings, the ex_mem / mem_wb pipeline register
// layouts and the memory-stage FSM encoding.
package rv32i_types;

  localparam logic [6:0] op_load  = 7'b0000011;
  localparam logic [6:0] op_store = 7'b0100011;
  localparam logic [6:0] op_imm   = 7'b0010011;
  localparam logic [6:0] op_reg   = 7'b0110011;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    mem_idle = 2'd0,
    mem_wait = 2'd1,
    mem_hold = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] alu_out;
    logic [31:0] rs2_v;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_addr;
    logic        regf_we;
    logic [31:0] alu_out;
    logic [31:0] rs2_v;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        misalign;
  } mem_wb_stage_reg_t;

  // Forward an ex_mem instruction into the mem_wb layout together with the
  // memory request that was (or was not) made for it.
  function automatic mem_wb_stage_reg_t to_mem_wb(
    input ex_mem_stage_reg_t ex,
    input logic [31:0]       addr,
    input logic [3:0]        rmask,
    input logic [3:0]        wmask,
    input logic [31:0]       wdata,
    input logic              misalign
  );
    mem_wb_stage_reg_t wb;
    wb.valid      = ex.valid;
    wb.pc         = ex.pc;
    wb.inst       = ex.inst;
    wb.opcode     = ex.opcode;
    wb.funct3     = ex.funct3;
    wb.rd_addr    = ex.rd_addr;
    wb.regf_we    = ex.regf_we;
    wb.alu_out    = ex.alu_out;
    wb.rs2_v      = ex.rs2_v;
    wb.dmem_addr  = addr;
    wb.dmem_rmask = rmask;
    wb.dmem_wmask = wmask;
    wb.dmem_wdata = wdata;
    wb.misalign   = misalign;
    return wb;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for data-memory accesses.
// Ports:
//   opcode, funct3 : instruction selectors (only loads/stores produce masks)
//   off            : byte offset within the word (alu_out[1:0])
//   rs2_v          : store source value
//   rmask, wmask   : byte masks; zero for non-memory ops, bad funct3 or misalignment
//   wdata          : store data shifted into its byte lanes
//   misalign       : half access on odd offset or word access on nonzero offset
module dmem_lane_align
  import rv32i_types::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2_v,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic        misalign
);

  logic [3:0] byte_mask;
  logic [3:0] half_mask;
  logic       half_bad;
  logic       word_bad;

  assign byte_mask = 4'b0001 << off;
  assign half_mask = 4'b0011 << {off[1], 1'b0};
  assign half_bad  = off[0];
  assign word_bad  = |off;

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    rmask    = '0;
    wmask    = '0;
    wdata    = '0;
    misalign = 1'b0;
    if (opcode == op_load) begin
      case (funct3)
        lb, lbu: rmask = byte_mask;
        lh, lhu: begin
          misalign = half_bad;
          rmask    = half_bad ? 4'b0000 : half_mask;
        end
        lw: begin
          misalign = word_bad;
          rmask    = word_bad ? 4'b0000 : 4'b1111;
        end
        default: rmask = '0;
      endcase
    end else if (opcode == op_store) begin
      wdata = rs2_v << {off, 3'b000};
      case (funct3)
        sb: wmask = byte_mask;
        sh: begin
          misalign = half_bad;
          wmask    = half_bad ? 4'b0000 : half_mask;
        end
        sw: begin
          misalign = word_bad;
          wmask    = word_bad ? 4'b0000 : 4'b1111;
        end
        default: wmask = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage. Issues one byte-masked, word-aligned data-memory
// request per load/store, holds it until dmem_resp, stalls upstream while
// the access is outstanding and produces the mem_wb register.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   ex_mem            : incoming instruction from execute
//   freeze_stall      : global stall; holds mem_wb and FSM state
//   dmem_addr/rmask/wmask/wdata : registered memory request
//   dmem_rdata, dmem_resp       : memory response
//   mem_stall         : upstream must hold ex_mem
//   mem_wb            : registered output to writeback
//   wb_dmem_rdata     : registered load data paired with mem_wb
//   wb_dmem_resp      : mem_wb holds a completed load
module mem_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  ex_mem_stage_reg_t ex_mem,
  input  logic              freeze_stall,
  output logic [31:0]       dmem_addr,
  output logic [3:0]        dmem_rmask,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              mem_stall,
  output mem_wb_stage_reg_t mem_wb,
  output logic [31:0]       wb_dmem_rdata,
  output logic              wb_dmem_resp
);

  mem_state_t        state_q, state_d;
  ex_mem_stage_reg_t ex_q, ex_d;          // instruction owning the request
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        rmask_q, rmask_d;    // masks as issued, kept for mem_wb
  logic [3:0]        wmask_q, wmask_d;
  logic [31:0]       rdata_q, rdata_d;    // response data parked during HOLD
  mem_wb_stage_reg_t mem_wb_q, mem_wb_d;
  logic [31:0]       wb_rdata_q, wb_rdata_d;
  logic              wb_resp_q, wb_resp_d;

  logic [3:0]  al_rmask, al_wmask;
  logic [31:0] al_wdata;
  logic        al_misalign;
  logic [31:0] req_addr;
  logic        issue_req;

  dmem_lane_align u_align (
    .opcode   (ex_mem.opcode),
    .funct3   (ex_mem.funct3),
    .off      (ex_mem.alu_out[1:0]),
    .rs2_v    (ex_mem.rs2_v),
    .rmask    (al_rmask),
    .wmask    (al_wmask),
    .wdata    (al_wdata),
    .misalign (al_misalign)
  );

  assign req_addr  = {ex_mem.alu_out[31:2], 2'b00};
  // A zero mask means misaligned, not a load/store, or an unknown funct3:
  // none of those may start a request that would wait forever.
  assign issue_req = ex_mem.valid && ((|al_rmask) || (|al_wmask));

  always_comb begin
    state_d    = state_q;
    ex_d       = ex_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rmask_d    = rmask_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    mem_wb_d   = mem_wb_q;
    wb_rdata_d = wb_rdata_q;
    wb_resp_d  = wb_resp_q;
    mem_stall  = 1'b0;

    case (state_q)
      mem_idle: begin
        mem_stall = issue_req;
        if (!freeze_stall) begin
          wb_resp_d = 1'b0;
          if (issue_req) begin
            ex_d           = ex_mem;
            addr_d         = req_addr;
            rmask_d        = al_rmask;
            wmask_d        = al_wmask;
            wdata_d        = al_wdata;
            mem_wb_d.valid = 1'b0;
            state_d        = mem_wait;
          end else begin
            mem_wb_d = to_mem_wb(ex_mem, req_addr, 4'b0000, 4'b0000, 32'h0,
                                 ex_mem.valid & al_misalign);
          end
        end
      end

      mem_wait: begin
        mem_stall = 1'b1;
        if (dmem_resp) begin
          rdata_d = dmem_rdata;
          if (!freeze_stall) begin
            mem_wb_d   = to_mem_wb(ex_q, addr_q, rmask_q, wmask_q, wdata_q, 1'b0);
            wb_rdata_d = dmem_rdata;
            wb_resp_d  = |rmask_q;
            state_d    = mem_idle;
          end else begin
            state_d = mem_hold;
          end
        end else if (!freeze_stall) begin
          mem_wb_d.valid = 1'b0;
          wb_resp_d      = 1'b0;
        end
      end

      mem_hold: begin
        mem_stall = 1'b1;
        if (!freeze_stall) begin
          mem_wb_d   = to_mem_wb(ex_q, addr_q, rmask_q, wmask_q, wdata_q, 1'b0);
          wb_rdata_d = rdata_q;
          wb_resp_d  = |rmask_q;
          state_d    = mem_idle;
        end
      end

      default: state_d = mem_idle;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  // NOTE: all state here is a handful of flops, so all of it is reset;
  // dropping the FSM to IDLE is what discards an in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= mem_idle;
      ex_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      mem_wb_q   <= '0;
      wb_rdata_q <= '0;
      wb_resp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_q       <= ex_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rmask_q    <= rmask_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      mem_wb_q   <= mem_wb_d;
      wb_rdata_q <= wb_rdata_d;
      wb_resp_q  <= wb_resp_d;
    end
  end

  // Masks are only presented while waiting, so they read zero in IDLE and
  // HOLD without a separate clear path on the issued-mask registers.
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_rmask    = (state_q == mem_wait) ? rmask_q : 4'b0000;
  assign dmem_wmask    = (state_q == mem_wait) ? wmask_q : 4'b0000;
  assign mem_wb        = mem_wb_q;
  assign wb_dmem_rdata = wb_rdata_q;
  assign wb_dmem_resp  = wb_resp_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage. Inputs change 1 ns after the
// rising edge; outputs are sampled 3 ns after the rising edge.
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  ex_mem_stage_reg_t ex_mem;
  logic              freeze_stall;
  logic [31:0]       dmem_addr;
  logic [3:0]        dmem_rmask;
  logic [3:0]        dmem_wmask;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              mem_stall;
  mem_wb_stage_reg_t mem_wb;
  logic [31:0]       wb_dmem_rdata;
  logic              wb_dmem_resp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_mem        (ex_mem),
    .freeze_stall  (freeze_stall),
    .dmem_addr     (dmem_addr),
    .dmem_rmask    (dmem_rmask),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .mem_stall     (mem_stall),
    .mem_wb        (mem_wb),
    .wb_dmem_rdata (wb_dmem_rdata),
    .wb_dmem_resp  (wb_dmem_resp)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic ex_mem_stage_reg_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [31:0] alu, input logic [31:0] rs2,
                                           input logic [4:0] rd);
    ex_mem_stage_reg_t e;
    e         = '0;
    e.valid   = 1'b1;
    e.pc      = 32'h0000_0400;
    e.inst    = 32'hC0DE_0000;
    e.opcode  = opc;
    e.funct3  = f3;
    e.rd_addr = rd;
    e.regf_we = (opc != op_store);
    e.alu_out = alu;
    e.rs2_v   = rs2;
    return e;
  endfunction

  initial begin
    rst          = 1'b0;
    ex_mem       = '0;
    freeze_stall = 1'b0;
    dmem_rdata   = '0;
    dmem_resp    = 1'b0;

    // Reset state
    settle();
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_rmask", dmem_rmask, 4'h0);
    check("rst_wmask", dmem_wmask, 4'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_mem_wb", mem_wb, '0);
    check("rst_wb_rdata", wb_dmem_rdata, 32'h0);
    check("rst_wb_resp", wb_dmem_resp, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // lw at 0x1000_0004, resp at N+3
    ex_mem = mk(op_load, lw, 32'h1000_0004, 32'h0, 5'd5);
    settle();
    check("lw_stall_n", mem_stall, 1'b1);
    check("lw_rmask_n", dmem_rmask, 4'h0);
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      if (k == 3) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
      end
      settle();
      check("lw_addr", dmem_addr, 32'h1000_0004);
      check("lw_rmask", dmem_rmask, 4'b1111);
      check("lw_stall", mem_stall, 1'b1);
      check("lw_bubble", mem_wb.valid, 1'b0);
    end
    next_cycle();
    ex_mem     = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    settle();
    check("lw_wb_valid", mem_wb.valid, 1'b1);
    check("lw_wb_rdata", wb_dmem_rdata, 32'hDEAD_BEEF);
    check("lw_wb_resp", wb_dmem_resp, 1'b1);
    check("lw_wb_rmask", mem_wb.dmem_rmask, 4'b1111);
    check("lw_wb_rd", mem_wb.rd_addr, 5'd5);
    check("lw_rmask_clr", dmem_rmask, 4'h0);
    check("lw_stall_clr", mem_stall, 1'b0);
    next_cycle();
    settle();
    check("lw_wb_single", mem_wb.valid, 1'b0);

    // sb at 0x2003
    ex_mem = mk(op_store, sb, 32'h0000_2003, 32'h0000_00A5, 5'd0);
    settle();
    check("sb_stall_n", mem_stall, 1'b1);
    next_cycle();
    dmem_resp = 1'b1;
    settle();
    check("sb_addr", dmem_addr, 32'h0000_2000);
    check("sb_wmask", dmem_wmask, 4'b1000);
    check("sb_rmask", dmem_rmask, 4'b0000);
    check("sb_wdata", dmem_wdata, 32'hA500_0000);
    next_cycle();
    ex_mem    = '0;
    dmem_resp = 1'b0;
    settle();
    check("sb_wb_valid", mem_wb.valid, 1'b1);
    check("sb_wb_resp", wb_dmem_resp, 1'b0);
    check("sb_wb_wmask", mem_wb.dmem_wmask, 4'b1000);
    check("sb_wmask_clr", dmem_wmask, 4'b0000);

    // sh at 0x2002: upper half lanes
    next_cycle();
    ex_mem = mk(op_store, sh, 32'h0000_2002, 32'h0000_BEEF, 5'd0);
    next_cycle();
    dmem_resp = 1'b1;
    settle();
    check("sh_wmask", dmem_wmask, 4'b1100);
    check("sh_wdata", dmem_wdata, 32'hBEEF_0000);
    next_cycle();
    ex_mem    = '0;
    dmem_resp = 1'b0;
    settle();
    check("sh_wb_valid", mem_wb.valid, 1'b1);

    // Misaligned lh at 0x2001
    next_cycle();
    ex_mem = mk(op_load, lh, 32'h0000_2001, 32'h0, 5'd9);
    settle();
    check("mis_stall", mem_stall, 1'b0);
    next_cycle();
    ex_mem = '0;
    settle();
    check("mis_rmask", dmem_rmask, 4'h0);
    check("mis_wb_valid", mem_wb.valid, 1'b1);
    check("mis_wb_flag", mem_wb.misalign, 1'b1);
    check("mis_wb_rmask", mem_wb.dmem_rmask, 4'h0);
    check("mis_wb_resp", wb_dmem_resp, 1'b0);

    // Non-memory op: one-cycle pass-through
    next_cycle();
    ex_mem = mk(op_reg, 3'b000, 32'h0000_0055, 32'h0, 5'd7);
    settle();
    check("alu_stall", mem_stall, 1'b0);
    next_cycle();
    ex_mem = '0;
    settle();
    check("alu_wb_valid", mem_wb.valid, 1'b1);
    check("alu_wb_out", mem_wb.alu_out, 32'h55);
    check("alu_wb_mis", mem_wb.misalign, 1'b0);

    // Freeze during resp: resp at N+2, freeze N+2..N+4
    next_cycle();
    ex_mem = mk(op_load, lw, 32'h0000_3008, 32'h0, 5'd3);
    next_cycle();
    next_cycle();
    freeze_stall = 1'b1;
    dmem_resp    = 1'b1;
    dmem_rdata   = 32'h1234_5678;
    for (int k = 3; k <= 4; k++) begin
      next_cycle();
      dmem_resp  = 1'b0;
      dmem_rdata = '0;
      settle();
      check("frz_stall", mem_stall, 1'b1);
      check("frz_rmask", dmem_rmask, 4'h0);
      check("frz_wb_hold", mem_wb.valid, 1'b0);
    end
    next_cycle();
    freeze_stall = 1'b0;
    settle();
    check("frz_n5_stall", mem_stall, 1'b1);
    check("frz_n5_wb", mem_wb.valid, 1'b0);
    next_cycle();
    ex_mem = '0;
    settle();
    check("frz_wb_valid", mem_wb.valid, 1'b1);
    check("frz_wb_rdata", wb_dmem_rdata, 32'h1234_5678);
    check("frz_wb_resp", wb_dmem_resp, 1'b1);
    check("frz_stall_clr", mem_stall, 1'b0);

    // Reset mid-access
    next_cycle();
    ex_mem = mk(op_load, lw, 32'h0000_5000, 32'h0, 5'd4);
    next_cycle();
    settle();
    check("rma_rmask", dmem_rmask, 4'b1111);
    rst    = 1'b0;
    ex_mem = '0;
    #1;
    check("rma_rmask0", dmem_rmask, 4'h0);
    check("rma_addr0", dmem_addr, 32'h0);
    check("rma_stall0", mem_stall, 1'b0);
    check("rma_wb0", mem_wb, '0);
    check("rma_rdata0", wb_dmem_rdata, 32'h0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    next_cycle();
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    settle();
    check("rma_wb_valid", mem_wb.valid, 1'b0);
    check("rma_wb_resp", wb_dmem_resp, 1'b0);
    check("rma_wb_rdata", wb_dmem_rdata, 32'h0);
    check("rma_stall", mem_stall, 1'b0);

    // Back-to-back sw with 1-cycle responses
    next_cycle();
    ex_mem = mk(op_store, sw, 32'h0000_4000, 32'h1111_1111, 5'd0);
    next_cycle();
    dmem_resp = 1'b1;
    settle();
    check("b2b_wmask1", dmem_wmask, 4'b1111);
    next_cycle();
    ex_mem    = mk(op_store, sw, 32'h0000_4004, 32'h2222_2222, 5'd0);
    dmem_resp = 1'b0;
    settle();
    check("b2b_gap_wmask", dmem_wmask, 4'b0000);
    check("b2b_wb1_valid", mem_wb.valid, 1'b1);
    check("b2b_wb1_wdata", mem_wb.dmem_wdata, 32'h1111_1111);
    check("b2b_issue2", mem_stall, 1'b1);
    next_cycle();
    dmem_resp = 1'b1;
    settle();
    check("b2b_wmask2", dmem_wmask, 4'b1111);
    check("b2b_addr2", dmem_addr, 32'h0000_4004);
    check("b2b_wdata2", dmem_wdata, 32'h2222_2222);
    check("b2b_wb_bubble", mem_wb.valid, 1'b0);
    next_cycle();
    ex_mem    = '0;
    dmem_resp = 1'b0;
    settle();
    check("b2b_wb2_valid", mem_wb.valid, 1'b1);
    check("b2b_wb2_addr", mem_wb.dmem_addr, 32'h0000_4004);
    check("b2b_wb2_wdata", mem_wb.dmem_wdata, 32'h2222_2222);
    next_cycle();
    settle();
    check("b2b_wb2_single", mem_wb.valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
